// File: rtl/chip8_mem.sv
// chip8_mem: CHIP-8 main memory. Boot sequencer clears the array, installs the hex font,
// streams a program in from the loader, then serves the CPU through one registered port.
module chip8_mem #(
   parameter int unsigned ADDR_W         = 12,
   parameter int unsigned FONT_BASE      = 0,
   parameter int unsigned PROG_BASE      = 512,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   parameter bit          LOAD_ENABLE    = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [7:0]        load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_overflow,
   output logic              ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [7:0]        din,
   output logic [7:0]        dout
);
   localparam int unsigned       DEPTH     = 1 << ADDR_W;
   localparam int unsigned       FONT_LEN  = 80;
   localparam logic [ADDR_W-1:0] TOP_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] FONT_LAST = ADDR_W'(FONT_LEN - 1);

   // Glyphs 0..F, five rows each; byte 0 sits in the most significant position.
   localparam logic [FONT_LEN*8-1:0] FONT_ROM = {
      8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
      8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
      8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
      8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
      8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
      8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
      8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
   };

   typedef enum logic [1:0] {S_CLEAR, S_FONT, S_LOAD, S_RUN} state_t;
   localparam state_t BOOT_STATE = CLEAR_ON_RESET ? S_CLEAR : S_FONT;
   localparam state_t FONT_NEXT  = LOAD_ENABLE ? S_LOAD : S_RUN;

   logic [7:0]        mem [DEPTH];
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              load_ready_q, load_ready_d;
   logic              overflow_q, overflow_d;
   logic              ready_q, ready_d;
   logic [7:0]        dout_q, dout_d;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [7:0]        mem_wdata;
   logic              xfer;
   logic [9:0]        font_sel;

   assign font_sel = 10'd632 - {cnt_q[6:0], 3'b000};

   // Sequencer: cnt_q is the write address in CLEAR/LOAD and the glyph byte index in FONT.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      dout_d     = 8'h00;
      mem_we     = 1'b0;
      mem_waddr  = cnt_q;
      mem_wdata  = 8'h00;
      xfer       = load_valid & load_ready_q;
      case (state_q)
         S_CLEAR: begin
            mem_we = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == TOP_ADDR) begin
               state_d = S_FONT;
               cnt_d   = '0;
            end
         end
         S_FONT: begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(FONT_BASE) + cnt_q;
            mem_wdata = FONT_ROM[font_sel +: 8];
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == FONT_LAST) begin
               state_d = FONT_NEXT;
               cnt_d   = ADDR_W'(PROG_BASE);
            end
         end
         S_LOAD: begin
            if (xfer) begin
               // Once the top byte is written the counter stays put and later bytes are dropped.
               if (full_q) begin
                  overflow_d = 1'b1;
               end else begin
                  mem_we    = 1'b1;
                  mem_wdata = load_data;
                  if (cnt_q == TOP_ADDR) full_d = 1'b1;
                  else                   cnt_d  = cnt_q + 1'b1;
               end
               if (load_last) state_d = S_RUN;
            end
         end
         S_RUN: begin
            mem_we    = we;
            mem_waddr = addr;
            mem_wdata = din;
            dout_d    = mem[addr];
         end
         default: state_d = BOOT_STATE;
      endcase
      load_ready_d = (state_d == S_LOAD);
      ready_d      = (state_d == S_RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BOOT_STATE;
         cnt_q        <= '0;
         full_q       <= 1'b0;
         overflow_q   <= 1'b0;
         load_ready_q <= 1'b0;
         ready_q      <= 1'b0;
         dout_q       <= 8'h00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         full_q       <= full_d;
         overflow_q   <= overflow_d;
         load_ready_q <= load_ready_d;
         ready_q      <= ready_d;
         dout_q       <= dout_d;
      end
   end

   // Single write port; the RUN read above samples the old byte, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
   end

   assign load_ready    = load_ready_q;
   assign load_overflow = overflow_q;
   assign ready         = ready_q;
   assign dout          = dout_q;
endmodule
